// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock switch sequencer: gate off, settle, move the mux, settle, gate on.
// Optional completed-switch counter is enabled by defining CLK_SWITCH_COUNT_EN.
module clk_switch_ctrl #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_sel,
    output logic        req_ready,
    output logic        selection,
    output logic        gate_en1,
    output logic        gate_en2,
    output logic        busy,
    output logic        done,
    output logic [15:0] switch_count
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] GATE_OFF   = 2'd1;
    localparam logic [1:0] MUX_SETTLE = 2'd2;
    localparam logic [1:0] GATE_ON    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             gate1_q, gate1_d;
    logic             gate2_q, gate2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gate_on_now;

    assign req_ready = (state_q == IDLE) && !reset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gate1_d     = gate1_q;
        gate2_d     = gate2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gate_on_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = GATE_OFF;
                        gate1_d = 1'b0;
                        gate2_d = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = MUX_SETTLE;
                    sel_d   = ~sel_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUX_SETTLE: begin
                // GATE_ON is taken on the same edge that ends the settle phase
                if (cnt_q == CNT_LAST) begin
                    gate_on_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gate_on_now = 1'b1;
            end
        endcase

        if (gate_on_now) begin
            state_d = IDLE;
            cnt_d   = '0;
            gate1_d = ~sel_q;
            gate2_d = sel_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            gate1_q <= 1'b1;
            gate2_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gate1_q <= gate1_d;
            gate2_q <= gate2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign selection = sel_q;
    assign gate_en1  = gate1_q;
    assign gate_en2  = gate2_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CLK_SWITCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            count_q <= '0;
        end else if (gate_on_now && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign switch_count = count_q;
`else
    assign switch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with SETTLE_CYCLES = 8.
// Counter expectations follow CLK_SWITCH_COUNT_EN when defined.
module tb_clk_switch_ctrl;

    localparam int S = 8;

    logic        aclk;
    logic        reset;
    logic        req_valid;
    logic        req_sel;
    logic        req_ready;
    logic        selection;
    logic        gate_en1;
    logic        gate_en2;
    logic        busy;
    logic        done;
    logic [15:0] switch_count;

    int tests;
    int fails;

    clk_switch_ctrl #(.SETTLE_CYCLES(S)) dut (
        .aclk         (aclk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_sel      (req_sel),
        .req_ready    (req_ready),
        .selection    (selection),
        .gate_en1     (gate_en1),
        .gate_en2     (gate_en2),
        .busy         (busy),
        .done         (done),
        .switch_count (switch_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1);
    end

    // inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    function automatic logic [5:0] snap();
        return {selection, gate_en1, gate_en2, busy, done, req_ready};
    endfunction

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
        repeat (3) tick();
        got = snap();
        tests++;
        if (got !== 6'b0_1_0_0_0_0) begin
            fails++;
            $display("FAIL reset_outputs: {sel,g1,g2,busy,done,rdy} got=%b required=%b", got, 6'b010000);
        end
        tests++;
        if (switch_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_count: got=%0d required=0", switch_count);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got=%b required=1", req_ready);
        end
    endtask

    task automatic test_same_select();
        logic [5:0] got;
        req_valid = 1'b1; req_sel = 1'b0;
        tick();
        req_valid = 1'b0;
        got = snap();
        tests++;
        if (got !== 6'b0_1_0_0_1_1) begin
            fails++;
            $display("FAIL same_select_pulse: got=%b required=%b", got, 6'b010011);
        end
        tick();
        got = snap();
        tests++;
        if (got !== 6'b0_1_0_0_0_1) begin
            fails++;
            $display("FAIL same_select_after: got=%b required=%b", got, 6'b010001);
        end
    endtask

    // switch from selection `from` to ~from; optionally hammer requests while busy
    task automatic run_switch(input logic from, input logic hammer, input string name);
        logic [5:0] got;
        logic [5:0] exp;
        logic       s;
        req_valid = 1'b1; req_sel = ~from;
        tick();
        if (!hammer) req_valid = 1'b0;
        got = snap();
        exp = {from, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s_accept: got=%b required=%b", name, got, exp);
        end
        for (int i = 1; i <= 2 * S; i++) begin
            if (hammer) req_sel = i[0];
            tick();
            s = (i >= S) ? ~from : from;
            if (i == 2 * S)
                exp = {s, ~s, s, 1'b0, 1'b1, 1'b1};
            else
                exp = {s, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            got = snap();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s_cycle%0d: got=%b required=%b", name, i, got, exp);
            end
        end
        req_valid = 1'b0;
        tick();
        got = snap();
        exp = {~from, from, ~from, 1'b0, 1'b0, 1'b1};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s_settled: got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic test_basic_switch();
        run_switch(1'b0, 1'b0, "basic_switch");
    endtask

    task automatic test_busy_requests();
        run_switch(1'b1, 1'b1, "busy_requests");
    endtask

    task automatic test_reset_mid_switch();
        logic [5:0] got;
        req_valid = 1'b1; req_sel = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (S + 2) tick();
        tests++;
        if ({selection, gate_en1, gate_en2, busy} !== 4'b1_0_0_1) begin
            fails++;
            $display("FAIL midswitch_state: {sel,g1,g2,busy} got=%b required=1001",
                     {selection, gate_en1, gate_en2, busy});
        end
        reset = 1'b1;
        tick();
        got = snap();
        tests++;
        if (got !== 6'b0_1_0_0_0_0) begin
            fails++;
            $display("FAIL midswitch_reset: got=%b required=%b", got, 6'b010000);
        end
        reset = 1'b0;
        for (int i = 0; i < 2 * S; i++) begin
            tick();
            got = snap();
            tests++;
            if (got !== 6'b0_1_0_0_0_1) begin
                fails++;
                $display("FAIL midswitch_after%0d: got=%b required=%b", i, got, 6'b010001);
            end
        end
    endtask

    task automatic do_request(input logic sel, input string name);
        int n;
        req_valid = 1'b1; req_sel = sel;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 4 * S) begin
            tick();
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: done got=%b required=1 within %0d cycles", name, done, 4 * S);
        end
        tick();
    endtask

    task automatic test_counter();
        logic [15:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_request(1'b0, "cnt_same_a");
        do_request(1'b1, "cnt_sw_1");
        do_request(1'b1, "cnt_same_b");
        do_request(1'b0, "cnt_sw_2");
        do_request(1'b1, "cnt_sw_3");
        do_request(1'b1, "cnt_same_c");
        do_request(1'b0, "cnt_sw_4");
        do_request(1'b1, "cnt_sw_5");
`ifdef CLK_SWITCH_COUNT_EN
        exp = 16'd5;
`else
        exp = 16'd0;
`endif
        tests++;
        if (switch_count !== exp) begin
            fails++;
            $display("FAIL switch_count: got=%0d required=%0d", switch_count, exp);
        end
        tests++;
        if (selection !== 1'b1) begin
            fails++;
            $display("FAIL counter_final_sel: got=%b required=1", selection);
        end
    endtask

    task automatic test_invariant();
        logic p_sel, p_g1, p_g2;
        int   bad;
        bad = 0;
        p_sel = selection; p_g1 = gate_en1; p_g2 = gate_en2;
        for (int c = 0; c < 10000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if ((gate_en1 & gate_en2) !== 1'b0) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL inv_both_gates cyc%0d: g1=%b g2=%b required not both 1", c, gate_en1, gate_en2);
            end
            tests++;
            if (selection !== p_sel && (p_g1 | p_g2 | gate_en1 | gate_en2) !== 1'b0) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL inv_sel_change cyc%0d: sel %b->%b gates %b%b->%b%b required gates 00", c, p_sel, selection, p_g1, p_g2, gate_en1, gate_en2);
            end
            tests++;
            if (busy === 1'b0 && {gate_en1, gate_en2} !== {~selection, selection}) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL inv_idle_gates cyc%0d: g1g2=%b%b required=%b%b", c, gate_en1, gate_en2, ~selection, selection);
            end
`ifndef CLK_SWITCH_COUNT_EN
            tests++;
            if (switch_count !== 16'd0) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL inv_count_zero cyc%0d: got=%0d required=0", c, switch_count);
            end
`endif
            p_sel = selection; p_g1 = gate_en1; p_g2 = gate_en2;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_sel = 1'b0;
        @(negedge aclk);
        test_reset();
        test_same_select();
        test_basic_switch();
        test_busy_requests();
        test_reset_mid_switch();
        test_counter();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, meaning the number of aclk cycles per quiet phase; legal range 1..255.
REQ-002 SHALL have port aclk, input, 1 bit: the single control clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a switch request is present.
REQ-005 SHALL have port req_sel, input, 1 bit: requested source, 0 = clock 1, 1 = clock 2.
REQ-006 SHALL have port req_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-007 SHALL have port selection, output, 1 bit: drives the clock mux select.
REQ-008 SHALL have port gate_en1, output, 1 bit: gate enable for clock 1.
REQ-009 SHALL have port gate_en2, output, 1 bit: gate enable for clock 2.
REQ-010 SHALL have port busy, output, 1 bit: a switch is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port switch_count, output, 16 bits: number of completed switches.

Function
REQ-013 SHALL implement the states IDLE, GATE_OFF, MUX_SETTLE and GATE_ON.
REQ-014 SHALL drive req_ready = 1 only in state IDLE while reset is low; a request is accepted on an edge where req_valid & req_ready.
REQ-015 SHALL, on an accepted request with req_sel == selection, stay in IDLE, leave all gates and selection unchanged, and assert done for exactly one cycle after the edge.
REQ-016 SHALL, on an accepted request with req_sel != selection (edge k), enter GATE_OFF; after edge k, both gate_en1 and gate_en2 = 0 and busy = 1.
REQ-017 SHALL hold GATE_OFF for SETTLE_CYCLES edges, then enter MUX_SETTLE; selection takes the new value after edge k+SETTLE_CYCLES.
REQ-018 SHALL hold MUX_SETTLE for SETTLE_CYCLES edges, then pass through GATE_ON and return to IDLE.
REQ-019 SHALL, after edge k+2*SETTLE_CYCLES, drive the newly selected gate = 1, the other gate = 0, busy = 0, done = 1 for one cycle, and req_ready = 1.
REQ-020 SHALL give a total switch latency of exactly 2*SETTLE_CYCLES cycles from acceptance to done.
REQ-021 SHALL never assert both gates at once, and SHALL never change selection while either gate is 1.
REQ-022 SHALL ignore req_valid and req_sel while busy; no request is queued.
REQ-023 SHALL use a single phase counter of width ceil(log2(SETTLE_CYCLES+1)), cleared on each phase entry.
REQ-024 SHALL make all outputs except req_ready registered.

Reset
REQ-025 SHALL, while reset = 1, force state IDLE, selection = 0, gate_en1 = 1, gate_en2 = 0, busy = 0, done = 0, req_ready = 0, counter = 0 and switch_count = 0.
REQ-026 SHALL, when reset asserts mid-switch, abort the switch and restore the values in REQ-025 on the next edge, with no done pulse.

Configuration
REQ-027 SHALL include the switch counter only when CLK_SWITCH_COUNT_EN is defined.
REQ-028 SHALL, with CLK_SWITCH_COUNT_EN defined, increment switch_count by 1 on each done pulse of a real switch (REQ-019) and saturate at 0xFFFF; same-select requests do not count.
REQ-029 SHALL, without CLK_SWITCH_COUNT_EN, tie switch_count to constant 0 and instantiate no counter register.

Verification
REQ-030 SHALL verify the basic switch: reset, then request req_sel=1 at cycle 10 with SETTLE_CYCLES=8 -> gates both 0 from cycle 11, selection=1 from cycle 19, gate_en2=1 and done pulse at cycle 27.
REQ-031 SHALL verify the same-select case: request req_sel=0 right after reset -> one-cycle done pulse, busy stays 0, and selection and gates are unchanged.
REQ-032 SHALL verify requests while busy: hold req_valid=1 with toggling req_sel throughout a switch -> req_ready=0, no extra transitions, and exactly one done pulse.
REQ-033 SHALL verify reset mid-switch: assert reset during MUX_SETTLE -> next cycle selection=0, gate_en1=1, gate_en2=0, busy=0, and no done pulse.
REQ-034 SHALL verify the invariant: with random requests over 10000 cycles, gate_en1 & gate_en2 is never 1 and selection never changes while a gate is high.
REQ-035 SHALL verify the counter: with CLK_SWITCH_COUNT_EN defined, 5 real switches plus 3 same-select requests -> switch_count=5; without the macro, switch_count=0 throughout.
